// File: rtl/sha256_msg_sched_if.sv
// rtl/sha256_msg_sched_if.sv - message-word input and schedule-word output handshakes
// master: block/round-logic environment side; slave: the schedule producer.
interface sha256_msg_sched_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [5:0]            out_round;
   logic                  out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_round, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_round, out_last
   );
endinterface

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule producer
// Loads 16 message words, then streams W[0..ROUNDS-1] from a 16-word window expanded in place.
module sha256_msg_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int ROUNDS     = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   sha256_msg_sched_if.slave  bus
);
   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            cnt;
   logic [5:0]            t;
   logic [DATA_WIDTH-1:0] win [16];
   logic [DATA_WIDTH-1:0] w_new;
   logic                  in_fire;
   logic                  out_fire;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   // Next window word; only ever feeds win[15], never the output path.
   assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD: if (in_fire && (cnt == 4'd15)) state_nxt = EMIT;
         EMIT: if (out_fire && (t == LAST_T)) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == LOAD);
      bus.out_valid = (state == EMIT);
      bus.out_last  = (state == EMIT) && (t == LAST_T);
   end

   // cnt wraps 15->0 on the final load, leaving it ready for the next block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 4'd0;
         t   <= 6'd0;
         for (int k = 0; k < 16; k++) begin
            win[k] <= '0;
         end
      end else begin
         if (in_fire) begin
            win[cnt] <= bus.in_data;
            cnt      <= cnt + 4'd1;
         end
         if (out_fire) begin
            for (int k = 0; k < 15; k++) begin
               win[k] <= win[k+1];
            end
            win[15] <= w_new;
            t       <= (t == LAST_T) ? 6'd0 : t + 6'd1;
         end
      end
   end

   assign bus.out_data  = win[0];
   assign bus.out_round = t;
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - randomized bench for sha256_msg_sched against a schedule model
module tb_sha256_msg_sched;
   typedef logic [31:0] blk16_t [16];
   typedef logic [31:0] w64_t [64];

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   sha256_msg_sched_if #(.DATA_WIDTH(32)) bus ();

   sha256_msg_sched #(.DATA_WIDTH(32), .ROUNDS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook recurrence over the full W array.
   function automatic w64_t ref_sched(input blk16_t m);
      w64_t w;
      for (int i = 0; i < 64; i++) begin
         if (i < 16) begin
            w[i] = m[i];
         end else begin
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10))
                 + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-16];
         end
      end
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input blk16_t m, input int max_gap);
      int guard;
      for (int i = 0; i < 16; i++) begin
         int gap;
         gap = int'($urandom_range(max_gap, 0));
         for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
            step();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = m[i];
         guard = 0;
         while (!bus.in_ready && guard < 100) begin
            step();
            guard++;
         end
         if (guard == 100) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
         end
         step();
      end
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
   endtask

   task automatic recv_block(input w64_t w, input int n_words, input int ready_pct, input bit noise);
      int k = 0;
      int cycles = 0;
      logic [31:0] hold_d;
      logic [5:0]  hold_r;
      logic        hold_l;
      while (k < n_words && cycles < 2000) begin
         bus.out_ready = (int'($urandom_range(99, 0)) < ready_pct);
         if (noise) begin
            bus.in_valid = 1'($urandom_range(1, 0));
            bus.in_data  = $urandom;
         end
         if (bus.out_valid && bus.out_ready) begin
            check($sformatf("w[%0d]", k), bus.out_data, w[k]);
            check($sformatf("round[%0d]", k), 32'(bus.out_round), 32'(k));
            check($sformatf("last[%0d]", k), 32'(bus.out_last), 32'(k == 63));
            check("in_ready_emit", 32'(bus.in_ready), 32'd0);
            step();
            k++;
         end else if (bus.out_valid) begin
            hold_d = bus.out_data;
            hold_r = bus.out_round;
            hold_l = bus.out_last;
            step();
            check("stall_data", bus.out_data, hold_d);
            check("stall_round", 32'(bus.out_round), 32'(hold_r));
            check("stall_last", 32'(bus.out_last), 32'(hold_l));
         end else begin
            check("out_valid_emit", 32'(bus.out_valid), 32'd1);
            step();
         end
         cycles++;
      end
      if (k < n_words) check("recv_timeout", 32'(k), 32'(n_words));
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   task automatic run_block(input blk16_t m, input int max_gap, input int ready_pct, input bit noise);
      w64_t w;
      w = ref_sched(m);
      send_block(m, max_gap);
      check("first_valid", 32'(bus.out_valid), 32'd1);
      check("first_in_ready", 32'(bus.in_ready), 32'd0);
      recv_block(w, 64, ready_pct, noise);
      check("bubble_in_ready", 32'(bus.in_ready), 32'd1);
      check("bubble_out_valid", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      blk16_t abc;
      blk16_t zero;
      blk16_t r1;
      blk16_t r2;
      w64_t   wz;
      w64_t   wabc;

      for (int i = 0; i < 16; i++) begin
         abc[i]  = 32'h0;
         zero[i] = 32'h0;
         r1[i]   = $urandom;
         r2[i]   = $urandom;
      end
      abc[0]  = 32'h61626380;
      abc[15] = 32'h00000018;
      wz   = ref_sched(zero);
      wabc = ref_sched(abc);

      rst_n        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.out_ready = 1'b0;
      repeat (3) step();
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", bus.out_data, 32'h0);
      check("rst_out_round", 32'(bus.out_round), 32'd0);
      check("rst_out_last", 32'(bus.out_last), 32'd0);
      rst_n = 1'b1;
      step();

      check("model_w16", wabc[16], 32'h61626380);
      check("model_w17", wabc[17], 32'h000F0000);
      run_block(abc, 0, 100, 1'b0);
      run_block(zero, 0, 100, 1'b0);
      run_block(abc, 0, 50, 1'b0);
      run_block(abc, 3, 70, 1'b1);

      send_block(zero, 0);
      recv_block(wz, 20, 100, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_in_ready", 32'(bus.in_ready), 32'd1);
      check("async_out_round", 32'(bus.out_round), 32'd0);
      check("async_out_data", bus.out_data, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();
      run_block(zero, 1, 100, 1'b0);

      run_block(r1, 0, 100, 1'b0);
      check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      run_block(r2, 0, 100, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
